// File: rtl/simple_proc_ctrl_if.sv
// Control-unit interface of the simple processor.
// master: controller side (simple_proc_ctrl); slave: datapath / switch side.
//   run, din          : start request and switch input (to controller)
//   tick, ir          : step state (one-hot T0..T3) and instruction register
//   ir_load, reg_in   : IR capture strobe, one-hot R0..R7 write enables
//   bus_sel           : bus source (0-7 Rk, 8 din, 9 G, 15 none)
//   a_in, g_in        : ALU operand A / result G latch strobes
//   addsub, done, busy: ALU op select, last tick, instruction in flight
interface simple_proc_ctrl_if;
  logic       run;
  logic [8:0] din;
  logic [3:0] tick;
  logic [8:0] ir;
  logic       ir_load;
  logic [7:0] reg_in;
  logic [3:0] bus_sel;
  logic       a_in;
  logic       g_in;
  logic       addsub;
  logic       done;
  logic       busy;

  modport master (
    input  run, din,
    output tick, ir, ir_load, reg_in, bus_sel, a_in, g_in, addsub, done, busy
  );

  modport slave (
    output run, din,
    input  tick, ir, ir_load, reg_in, bus_sel, a_in, g_in, addsub, done, busy
  );
endinterface

// File: rtl/simple_proc_ctrl.sv
// Control unit of the simple processor: instruction register plus one-hot
// tick FSM (T0..T3) decoding a 9-bit instruction {op[2:0], X[2:0], Y[2:0]}
// into datapath strobes.
//   clk     : processor clock
//   rst     : asynchronous active-high reset
//   ctrl_if : controller side of simple_proc_ctrl_if (run/din in, strobes out)
module simple_proc_ctrl (
  input  logic                       clk,
  input  logic                       rst,
  simple_proc_ctrl_if.master         ctrl_if
);

  localparam int unsigned TICK_W = 4;
  localparam int unsigned IR_W   = 9;
  localparam int unsigned REG_N  = 8;
  localparam int unsigned SEL_W  = 4;

  localparam logic [TICK_W-1:0] T0 = 4'b0001;
  localparam logic [TICK_W-1:0] T1 = 4'b0010;
  localparam logic [TICK_W-1:0] T2 = 4'b0100;
  localparam logic [TICK_W-1:0] T3 = 4'b1000;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [SEL_W-1:0] SEL_DIN  = 4'd8;
  localparam logic [SEL_W-1:0] SEL_G    = 4'd9;
  localparam logic [SEL_W-1:0] SEL_NONE = 4'd15;

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [IR_W-1:0]   ir_q, ir_d;

  logic [2:0] op, rx, ry;
  logic       is_arith;

  assign op       = ir_q[8:6];
  assign rx       = ir_q[5:3];
  assign ry       = ir_q[2:0];
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);

  // State register: tick and instruction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= T0;
      ir_q   <= '0;
    end else begin
      tick_q <= tick_d;
      ir_q   <= ir_d;
    end
  end

  // Next-state: IR captured only in T0 with run; non-one-hot ticks recover to T0.
  always_comb begin
    tick_d = T0;
    ir_d   = ir_q;
    case (tick_q)
      T0: begin
        if (ctrl_if.run) begin
          ir_d   = ctrl_if.din;
          tick_d = T1;
        end
      end
      T1:      tick_d = is_arith ? T2 : T0;
      T2:      tick_d = T3;
      T3:      tick_d = T0;
      default: tick_d = T0;
    endcase
  end

  // Strobe decode from tick, ir and run.
  always_comb begin
    ctrl_if.ir_load = 1'b0;
    ctrl_if.reg_in  = '0;
    ctrl_if.bus_sel = SEL_NONE;
    ctrl_if.a_in    = 1'b0;
    ctrl_if.g_in    = 1'b0;
    ctrl_if.addsub  = 1'b0;
    ctrl_if.done    = 1'b0;
    ctrl_if.busy    = 1'b0;
    case (tick_q)
      T0: ctrl_if.ir_load = ctrl_if.run;
      T1: begin
        ctrl_if.busy = 1'b1;
        case (op)
          OP_MV: begin
            ctrl_if.bus_sel = {1'b0, ry};
            ctrl_if.reg_in  = REG_N'(1) << rx;
            ctrl_if.done    = 1'b1;
          end
          OP_MVI: begin
            ctrl_if.bus_sel = SEL_DIN;
            ctrl_if.reg_in  = REG_N'(1) << rx;
            ctrl_if.done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_if.bus_sel = {1'b0, rx};
            ctrl_if.a_in    = 1'b1;
          end
          default: ctrl_if.done = 1'b1;  // reserved opcodes retire as no-ops
        endcase
      end
      T2: begin
        ctrl_if.busy    = 1'b1;
        ctrl_if.bus_sel = {1'b0, ry};
        ctrl_if.g_in    = 1'b1;
        ctrl_if.addsub  = ir_q[6];
      end
      T3: begin
        ctrl_if.busy    = 1'b1;
        ctrl_if.bus_sel = SEL_G;
        ctrl_if.reg_in  = REG_N'(1) << rx;
        ctrl_if.done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl_if.tick = tick_q;
  assign ctrl_if.ir   = ir_q;

endmodule

// File: tb/tb_simple_proc_ctrl.sv
// Scoreboard bench for simple_proc_ctrl: stimulus pushes hand-computed
// expected output snapshots; the monitor pops and compares at each falling
// clock edge, or on demand while the clock is stopped / mid-cycle.
module tb_simple_proc_ctrl;

  typedef struct packed {
    logic [3:0] tick;
    logic [8:0] ir;
    logic       ir_load;
    logic [7:0] reg_in;
    logic [3:0] bus_sel;
    logic       a_in;
    logic       g_in;
    logic       addsub;
    logic       done;
    logic       busy;
  } exp_t;

  logic clk;
  logic clk_en;
  logic rst;

  simple_proc_ctrl_if u_if ();

  simple_proc_ctrl u_dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (u_if)
  );

  exp_t exp_q[$];
  event chk_ev;
  int   checks   = 0;
  int   failures = 0;
  int   step     = 0;

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  function automatic exp_t mk(input logic [3:0] t, input logic [8:0] i,
                              input logic il, input logic [7:0] ri,
                              input logic [3:0] bs, input logic a,
                              input logic g, input logic as,
                              input logic dn, input logic by);
    exp_t e;
    e.tick = t;  e.ir = i;  e.ir_load = il; e.reg_in = ri; e.bus_sel = bs;
    e.a_in = a;  e.g_in = g; e.addsub = as; e.done = dn;   e.busy = by;
    return e;
  endfunction

  // Idle T0 snapshot.
  function automatic exp_t t0(input logic [8:0] i, input logic r);
    return mk(4'b0001, i, r, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Monitor: pop and compare every pending expectation.
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = mk(u_if.tick, u_if.ir, u_if.ir_load, u_if.reg_in, u_if.bus_sel,
               u_if.a_in, u_if.g_in, u_if.addsub, u_if.done, u_if.busy);
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL step%0d: got tick=%b ir=%b ir_load=%b reg_in=%b bus_sel=%0d a_in=%b g_in=%b addsub=%b done=%b busy=%b | exp tick=%b ir=%b ir_load=%b reg_in=%b bus_sel=%0d a_in=%b g_in=%b addsub=%b done=%b busy=%b",
                   step, g.tick, g.ir, g.ir_load, g.reg_in, g.bus_sel, g.a_in,
                   g.g_in, g.addsub, g.done, g.busy, e.tick, e.ir, e.ir_load,
                   e.reg_in, e.bus_sel, e.a_in, e.g_in, e.addsub, e.done, e.busy);
        end
        step++;
      end
    end
  end

  // One clock cycle: drive inputs just after the edge and queue the expectation.
  task automatic cyc(input logic rs, input logic r, input logic [8:0] d,
                     input exp_t e);
    @(posedge clk);
    #1;
    rst      = rs;
    u_if.run = r;
    u_if.din = d;
    exp_q.push_back(e);
  endtask

  // Immediate check without waiting for a clock edge.
  task automatic check_now(input exp_t e);
    exp_q.push_back(e);
    -> chk_ev;
    #0;
  endtask

  localparam logic [8:0] I_MVI   = 9'b001_010_000;
  localparam logic [8:0] I_ADD   = 9'b010_001_010;
  localparam logic [8:0] I_SUB   = 9'b011_011_011;
  localparam logic [8:0] I_RSV   = 9'b110_111_111;
  localparam logic [8:0] I_MV56  = 9'b000_101_110;
  localparam logic [8:0] I_MV01  = 9'b000_000_001;
  localparam logic [8:0] I_ADD70 = 9'b010_111_000;
  localparam logic [8:0] I_MV41  = 9'b000_100_001;

  initial begin
    clk_en   = 1'b0;
    rst      = 1'b0;
    u_if.run = 1'b0;
    u_if.din = '0;

    // Async reset with the clock stopped.
    #2 rst = 1'b1;
    #1 check_now(t0(9'd0, 1'b0));
    #1 u_if.run = 1'b1;
    #1 check_now(t0(9'd0, 1'b1));
    #1 u_if.run = 1'b0;

    clk_en = 1'b1;
    cyc(1'b1, 1'b0, 9'd0, t0(9'd0, 1'b0));
    cyc(1'b0, 1'b0, 9'd0, t0(9'd0, 1'b0));

    // mvi R2,#5
    cyc(1'b0, 1'b1, I_MVI, t0(9'd0, 1'b1));
    cyc(1'b0, 1'b0, 9'd5, mk(4'b0010, I_MVI, 1'b0, 8'b0000_0100, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    cyc(1'b0, 1'b0, 9'd0, t0(I_MVI, 1'b0));

    // add R1,R2 with run held high through T1-T2 (ignored)
    cyc(1'b0, 1'b1, I_ADD, t0(I_MVI, 1'b1));
    cyc(1'b0, 1'b1, 9'h1ff, mk(4'b0010, I_ADD, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 1'b1, 9'd0, mk(4'b0100, I_ADD, 1'b0, 8'h00, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 1'b0, 9'd0, mk(4'b1000, I_ADD, 1'b0, 8'b0000_0010, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    cyc(1'b0, 1'b0, 9'd0, t0(I_ADD, 1'b0));

    // sub R3,R3
    cyc(1'b0, 1'b1, I_SUB, t0(I_ADD, 1'b1));
    cyc(1'b0, 1'b0, 9'd0, mk(4'b0010, I_SUB, 1'b0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 1'b0, 9'd0, mk(4'b0100, I_SUB, 1'b0, 8'h00, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    cyc(1'b0, 1'b0, 9'd0, mk(4'b1000, I_SUB, 1'b0, 8'b0000_1000, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // run low for 5 cycles: hold in T0, ir unchanged despite din activity
    for (int k = 0; k < 5; k++)
      cyc(1'b0, 1'b0, 9'(9'h1ff - k), t0(I_SUB, 1'b0));

    // reserved opcode retires as a no-op
    cyc(1'b0, 1'b1, I_RSV, t0(I_SUB, 1'b1));
    cyc(1'b0, 1'b0, 9'd0, mk(4'b0010, I_RSV, 1'b0, 8'h00, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // back-to-back mv with run held high
    cyc(1'b0, 1'b1, I_MV56, t0(I_RSV, 1'b1));
    cyc(1'b0, 1'b1, 9'h1ff, mk(4'b0010, I_MV56, 1'b0, 8'b0010_0000, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    cyc(1'b0, 1'b1, I_MV01, t0(I_MV56, 1'b1));
    cyc(1'b0, 1'b0, 9'd0, mk(4'b0010, I_MV01, 1'b0, 8'b0000_0001, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // add R7,R0 abandoned by reset in T2
    cyc(1'b0, 1'b1, I_ADD70, t0(I_MV01, 1'b1));
    cyc(1'b0, 1'b0, 9'd0, mk(4'b0010, I_ADD70, 1'b0, 8'h00, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    @(posedge clk);
    #1 check_now(mk(4'b0100, I_ADD70, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    #1 rst = 1'b1;
    #1 check_now(t0(9'd0, 1'b0));
    cyc(1'b1, 1'b0, 9'd0, t0(9'd0, 1'b0));

    // mv R4,R1 after reset release
    cyc(1'b0, 1'b1, I_MV41, t0(9'd0, 1'b1));
    cyc(1'b0, 1'b0, 9'd0, mk(4'b0010, I_MV41, 1'b0, 8'b0001_0000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    cyc(1'b0, 1'b0, 9'd0, t0(I_MV41, 1'b0));

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
